// File: rtl/inpass_sync_frame_config.sv
// Input-pass BEL: NUM_CH independent channels, each configured by three frame
// bits to pass its (optionally inverted) input combinationally, registered,
// through a 2-FF synchroniser, or through the synchroniser plus a debouncer.
// Every register runs regardless of the selected mode, so a configuration
// change only moves the output mux and never disturbs channel state.
module inpass_sync_frame_config #(
  parameter int NUM_CH       = 4,
  parameter int DB_CYCLES    = 8,
  parameter int NoConfigBits = 3 * NUM_CH
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] MODE_COMB = 2'b00;
  localparam logic [1:0] MODE_REG  = 2'b01;
  localparam logic [1:0] MODE_SYNC = 2'b10;
  localparam logic [1:0] MODE_DB   = 2'b11;

  // Reject configurations that cannot describe a working channel.
  generate
    if (NUM_CH < 1) begin : g_bad_num_ch
      $error("inpass_sync_frame_config: NUM_CH must be >= 1");
    end
    if (DB_CYCLES < 1) begin : g_bad_db_cycles
      $error("inpass_sync_frame_config: DB_CYCLES must be >= 1");
    end
    if (NoConfigBits != 3 * NUM_CH) begin : g_bad_cfg_bits
      $error("inpass_sync_frame_config: NoConfigBits must equal 3*NUM_CH");
    end
  endgenerate

  logic [NUM_CH-1:0] x;
  logic [NUM_CH-1:0] s1_q, s1_d;
  logic [NUM_CH-1:0] s2_q, s2_d;
  logic [NUM_CH-1:0] db_q, db_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Apply per-channel inversion ahead of every stage.
  always_comb begin
    x = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      x[i] = I[i] ^ ConfigBits[3*i+2];
    end
  end

  // Next-state for the synchroniser chain and the debounce window.  A
  // deviation of s2 from db must persist for DB_CYCLES consecutive edges
  // before db follows; any return to agreement restarts the window.
  always_comb begin
    s1_d = x;
    s2_d = s1_q;
    db_d = db_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // State registers; reset discards any debounce in progress.
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-channel output select from the channel's two mode bits.
  always_comb begin
    O = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ConfigBits[3*i +: 2])
        MODE_COMB: O[i] = x[i];
        MODE_REG:  O[i] = s1_q[i];
        MODE_SYNC: O[i] = s2_q[i];
        MODE_DB:   O[i] = db_q[i];
        default:   O[i] = x[i];
      endcase
    end
  end

endmodule

// File: tb/tb_inpass_sync_frame_config.sv
// Directed bench for inpass_sync_frame_config with eight channels and an
// eight-cycle debounce window.
module tb_inpass_sync_frame_config;

  localparam int NUM_CH = 8;
  localparam int DB     = 8;
  localparam int NCB    = 3 * NUM_CH;

  logic              UserCLK = 1'b0;
  logic              UserRST;
  logic [NUM_CH-1:0] I;
  logic [NUM_CH-1:0] O;
  logic [NCB-1:0]    ConfigBits;

  int n_vec = 0;
  int n_err = 0;

  inpass_sync_frame_config #(
    .NUM_CH      (NUM_CH),
    .DB_CYCLES   (DB),
    .NoConfigBits(NCB)
  ) dut (
    .UserCLK   (UserCLK),
    .UserRST   (UserRST),
    .I         (I),
    .O         (O),
    .ConfigBits(ConfigBits)
  );

  // Free-running user clock, 10 time units per period.
  always #5 UserCLK = ~UserCLK;

  task automatic step();
    @(posedge UserCLK);
    #2;
  endtask

  task automatic set_cfg(input int ch, input logic [2:0] c);
    ConfigBits[3*ch +: 3] = c;
  endtask

  task automatic settle_after_reset(input int cycles);
    UserRST = 1'b1;
    step();
    UserRST = 1'b0;
    repeat (cycles) step();
  endtask

  task automatic test_reset();
    I = '1;
    for (int ch = 0; ch < NUM_CH; ch++) set_cfg(ch, 3'b110);
    UserRST = 1'b1;
    step();
    n_vec++;
    if (O !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset_first_edge O=%b expected=%b", O, 8'h00);
    end
    n_vec++;
    if (dut.s1_q !== 8'h00 || dut.s2_q !== 8'h00 || dut.db_q !== 8'h00 ||
        dut.cnt_q[0] !== 4'd0 || dut.cnt_q[7] !== 4'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state s1=%b s2=%b db=%b cnt0=%0d cnt7=%0d expected all zero",
               dut.s1_q, dut.s2_q, dut.db_q, dut.cnt_q[0], dut.cnt_q[7]);
    end
    step();
    n_vec++;
    if (O !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset_second_edge O=%b expected=%b", O, 8'h00);
    end
    set_cfg(0, 3'b000);
    #1;
    n_vec++;
    if (O !== 8'h01) begin
      n_err++;
      $display("[TB] FAIL reset_comb_passthrough O=%b expected=%b", O, 8'h01);
    end
    UserRST = 1'b0;
  endtask

  task automatic test_latency();
    logic [3:0] exp_o;
    I = '0;
    ConfigBits = '0;
    set_cfg(0, 3'b000);
    set_cfg(1, 3'b001);
    set_cfg(2, 3'b010);
    set_cfg(3, 3'b011);
    settle_after_reset(12);
    I[3:0] = 4'hF;
    #1;
    n_vec++;
    if (O[3:0] !== 4'b0001) begin
      n_err++;
      $display("[TB] FAIL latency_comb O=%b expected=%b", O[3:0], 4'b0001);
    end
    for (int j = 0; j <= 10; j++) begin
      step();
      exp_o = {(j >= 9), (j >= 1), 1'b1, 1'b1};
      n_vec++;
      if (O[3:0] !== exp_o) begin
        n_err++;
        $display("[TB] FAIL latency_edge_%0d O=%b expected=%b", j, O[3:0], exp_o);
      end
    end
  endtask

  task automatic test_bounce();
    int lens [2];
    logic exp_o;
    lens[0] = 7;
    lens[1] = 8;
    I = '0;
    ConfigBits = '0;
    set_cfg(3, 3'b011);
    settle_after_reset(12);
    for (int p = 0; p < 2; p++) begin
      I[3] = 1'b1;
      for (int j = 0; j <= 12; j++) begin
        step();
        exp_o = (lens[p] == 8) && (j >= 9);
        n_vec++;
        if (O[3] !== exp_o) begin
          n_err++;
          $display("[TB] FAIL bounce_len%0d_edge_%0d O3=%b expected=%b", lens[p], j, O[3], exp_o);
        end
        if (lens[p] == 7 && j == 8) begin
          n_vec++;
          if (dut.cnt_q[3] !== 4'd7) begin
            n_err++;
            $display("[TB] FAIL bounce_cnt_peak cnt=%0d expected=%0d", dut.cnt_q[3], 7);
          end
        end
        if (lens[p] == 7 && j == 9) begin
          n_vec++;
          if (dut.cnt_q[3] !== 4'd0) begin
            n_err++;
            $display("[TB] FAIL bounce_cnt_clear cnt=%0d expected=%0d", dut.cnt_q[3], 0);
          end
        end
        if (j + 1 == lens[p]) I[3] = 1'b0;
      end
      repeat (20) step();
    end
  endtask

  task automatic test_invert_switch();
    I = '0;
    ConfigBits = '0;
    set_cfg(0, 3'b101);
    UserRST = 1'b1;
    step();
    n_vec++;
    if (O[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL inv_reset O0=%b expected=%b", O[0], 1'b0);
    end
    UserRST = 1'b0;
    step();
    n_vec++;
    if (O[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL inv_registered O0=%b expected=%b", O[0], 1'b1);
    end
    set_cfg(0, 3'b100);
    #1;
    n_vec++;
    if (O[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL inv_mode_switch O0=%b expected=%b", O[0], 1'b1);
    end
    I[0] = 1'b1;
    #1;
    n_vec++;
    if (O[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL inv_comb O0=%b expected=%b", O[0], 1'b0);
    end
  endtask

  task automatic test_reset_mid_debounce();
    I = '0;
    ConfigBits = '0;
    set_cfg(2, 3'b011);
    settle_after_reset(12);
    I[2] = 1'b1;
    repeat (5) step();
    n_vec++;
    if (dut.cnt_q[2] !== 4'd3) begin
      n_err++;
      $display("[TB] FAIL middeb_cnt_before cnt=%0d expected=%0d", dut.cnt_q[2], 3);
    end
    UserRST = 1'b1;
    step();
    n_vec++;
    if (dut.cnt_q[2] !== 4'd0 || dut.db_q[2] !== 1'b0 || O[2] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL middeb_reset cnt=%0d db=%b O2=%b expected cnt=0 db=0 O2=0",
               dut.cnt_q[2], dut.db_q[2], O[2]);
    end
    UserRST = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      step();
      n_vec++;
      if (O[2] !== (j >= 10)) begin
        n_err++;
        $display("[TB] FAIL middeb_edge_%0d O2=%b expected=%b", j, O[2], (j >= 10));
      end
    end
  endtask

  task automatic test_isolation();
    bit   m_s1 [NUM_CH];
    bit   m_s2 [NUM_CH];
    bit   m_db [NUM_CH];
    int   m_cnt [NUM_CH];
    int   hold [NUM_CH];
    logic [NUM_CH-1:0] xv;
    logic [NUM_CH-1:0] exp_o;
    logic [2:0] c;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      c = 3'(ch);
      set_cfg(ch, c);
      m_s1[ch] = 0; m_s2[ch] = 0; m_db[ch] = 0; m_cnt[ch] = 0; hold[ch] = 0;
    end
    I = '0;
    UserRST = 1'b1;
    step();
    UserRST = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (hold[ch] == 0) begin
          I[ch]    = 1'($urandom_range(0, 1));
          hold[ch] = $urandom_range(1, 12);
        end
        hold[ch]--;
      end
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        c      = 3'(ch);
        xv[ch] = I[ch] ^ c[2];
        case (c[1:0])
          2'b00:   exp_o[ch] = xv[ch];
          2'b01:   exp_o[ch] = m_s1[ch];
          2'b10:   exp_o[ch] = m_s2[ch];
          default: exp_o[ch] = m_db[ch];
        endcase
      end
      n_vec++;
      if (O !== exp_o) begin
        n_err++;
        $display("[TB] FAIL iso_cycle_%0d O=%b expected=%b", cyc, O, exp_o);
      end
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (m_s2[ch] == m_db[ch]) begin
          m_cnt[ch] = 0;
        end else if (m_cnt[ch] == DB - 1) begin
          m_db[ch]  = m_s2[ch];
          m_cnt[ch] = 0;
        end else begin
          m_cnt[ch]++;
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = xv[ch];
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    UserRST    = 1'b1;
    I          = '0;
    ConfigBits = '0;
    test_reset();
    test_latency();
    test_bounce();
    test_invert_switch();
    test_reset_mid_debounce();
    test_isolation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
